// File: rtl/fetch_unit.sv
// fetch_unit: variable-length (1/2/3/5 byte) instruction fetch with one-deep output register, redirect and halt
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [7:0]  HALT_OPCODE = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] fetch_pc,
    input  logic [39:0] fetch_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [39:0] out_instr,
    output logic [31:0] out_pc,
    output logic [2:0]  out_len,
    output logic        halted,
    output logic [31:0] insn_count
);
    typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        out_valid_q, out_valid_d;
    logic [39:0] out_instr_q, out_instr_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [2:0]  out_len_q, out_len_d;
    logic [31:0] count_q, count_d;
    logic [2:0]  len;
    logic        is_halt;
    logic        capture;

    // length decode from the top two bits of the first byte, and capture enable
    always_comb begin
        len     = (fetch_instr[7:6] == 2'b00) ? 3'd1 :
                  (fetch_instr[7:6] == 2'b01) ? 3'd2 :
                  (fetch_instr[7:6] == 2'b10) ? 3'd3 : 3'd5;
        is_halt = (fetch_instr[7:0] == HALT_OPCODE);
        capture = (state_q == RUN) && !redirect_valid && (!out_valid_q || out_ready);
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // next state: redirect always resumes RUN, capturing the halt opcode stops fetching
    always_comb begin
        state_d = redirect_valid       ? RUN    :
                  (capture && is_halt) ? HALTED : state_q;
    end

    // state-derived outputs
    always_comb begin
        halted = (state_q == HALTED);
    end

    // datapath next values: redirect flushes, capture loads, handshake drains
    always_comb begin
        pc_d        = redirect_valid         ? redirect_pc :
                      (capture && !is_halt)  ? pc_q + {29'd0, len} : pc_q;
        out_valid_d = redirect_valid         ? 1'b0 :
                      capture                ? 1'b1 :
                      out_ready              ? 1'b0 : out_valid_q;
        out_instr_d = capture ? fetch_instr : out_instr_q;
        out_pc_d    = capture ? pc_q        : out_pc_q;
        out_len_d   = capture ? len         : out_len_q;
        count_d     = (out_valid_q && out_ready && !redirect_valid) ? count_q + 32'd1 : count_q;
    end

    // datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_instr_q <= 40'd0;
            out_pc_q    <= 32'd0;
            out_len_q   <= 3'd0;
            count_q     <= 32'd0;
        end else begin
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            out_len_q   <= out_len_d;
            count_q     <= count_d;
        end
    end

    assign fetch_pc   = pc_q;
    assign out_valid  = out_valid_q;
    assign out_instr  = out_instr_q;
    assign out_pc     = out_pc_q;
    assign out_len    = out_len_q;
    assign insn_count = count_q;
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The parameter RESET_PC SHALL default to 32'h0000_0000 and SHALL set the PC loaded on reset.
REQ-002 The parameter HALT_OPCODE SHALL default to 8'hFF and SHALL be the first-byte value that stops fetching.
REQ-003 clk SHALL be an input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 rst_n SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-005 fetch_pc SHALL be an output, 32 bits: byte address driven to the instruction memory; it equals the internal PC register.
REQ-006 fetch_instr SHALL be an input, 40 bits: little-endian 5-byte window from memory at fetch_pc, valid in the same cycle (combinational memory); byte 0 is bits [7:0].
REQ-007 redirect_valid SHALL be an input, 1 bit: a branch/jump redirect request.
REQ-008 redirect_pc SHALL be an input, 32 bits: the redirect target.
REQ-009 out_valid SHALL be an output, 1 bit: out_instr, out_pc and out_len hold a fetched instruction.
REQ-010 out_ready SHALL be an input, 1 bit: the downstream decode stage accepts the instruction.
REQ-011 out_instr SHALL be an output, 40 bits: the captured fetch window.
REQ-012 out_pc SHALL be an output, 32 bits: the address of out_instr.
REQ-013 out_len SHALL be an output, 3 bits: the instruction length in bytes (1, 2, 3 or 5).
REQ-014 halted SHALL be an output, 1 bit: the unit is in the HALTED state.
REQ-015 insn_count SHALL be an output, 32 bits: the number of completed output handshakes.

Function
REQ-016 The length decode SHALL use fetch_instr[7:6]: 00 gives 1, 01 gives 2, 10 gives 3, 11 gives 5.
REQ-017 A capture SHALL be enabled when state is RUN and redirect_valid=0 and (out_valid=0 or out_ready=1).
REQ-018 On a capture, the unit SHALL load out_instr<=fetch_instr, out_pc<=PC, out_len<=decoded length and out_valid<=1.
REQ-019 On a capture of a non-halt instruction, the PC SHALL be loaded with PC+len, modulo 2^32 (wraps at 32'hFFFF_FFFF without error).
REQ-020 On a capture where fetch_instr[7:0]==HALT_OPCODE, the instruction SHALL be output normally, the PC SHALL be unchanged, and state SHALL go RUN->HALTED.
REQ-021 In HALTED, the unit SHALL make no further captures; out_valid SHALL clear after the halt instruction handshakes and out_* SHALL then hold their values.
REQ-022 If out_valid=1 and out_ready=0, out_instr, out_pc, out_len and the PC SHALL all hold (stall).
REQ-023 If out_valid=0 and no capture occurs, out_valid SHALL stay 0.
REQ-024 Redirect SHALL have highest priority: redirect_valid=1 loads PC<=redirect_pc, sets out_valid<=0 (flushing any pending instruction even if out_ready=1), and sets state<=RUN from either state.
REQ-025 insn_count SHALL increment by 1 on every cycle with out_valid=1 and out_ready=1 and redirect_valid=0, and SHALL wrap modulo 2^32.
REQ-026 The fetch latency SHALL be one cycle: the window at PC N appears on out_* the cycle after PC=N is presented, giving a throughput of one instruction per cycle when out_ready=1.
REQ-027 The state machine SHALL have exactly two states, RUN and HALTED, encoded so that halted=1 exactly in HALTED.

Reset
REQ-028 While rst_n=0, regardless of clk: PC=RESET_PC, fetch_pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, out_len=0, state=RUN, halted=0, insn_count=0.
REQ-029 Reset asserted mid-stall or while HALTED SHALL discard the pending instruction; the first capture SHALL occur on the first rising edge after rst_n rises.

Verification
REQ-030 Sequential flow: memory bytes from 0 are 00 | 41 AA | 80 BB CC | C0 11 22 33 44 | FF, with out_ready=1 -> out_pc sequence 0,1,3,6,11, out_len sequence 1,2,3,5,5, halted=1 after PC 11, insn_count=5.
REQ-031 Stall: hold out_ready=0 for 3 cycles at out_pc=3 -> out_instr, out_pc=3 and fetch_pc=6 remain stable; on release out_pc=6 follows in the next cycle.
REQ-032 Redirect while stalled: out_valid=1, out_ready=0, redirect_pc=32'h20 -> next cycle out_valid=0, fetch_pc=32'h20; the following cycle out_pc=32'h20.
REQ-033 Redirect from HALTED to 32'h0 -> halted=0 and fetch resumes at out_pc=0.
REQ-034 Wrap: redirect to 32'hFFFF_FFFE with opcode 8'h80 -> next fetch_pc=32'h0000_0001.
REQ-035 Async reset mid-stream: drop rst_n between clock edges -> out_valid=0 and fetch_pc=RESET_PC immediately, and insn_count=0.
